// File: rtl/uart_transceiver.sv
// Full-duplex 8N1 UART: registered TX serializer and a synchronized RX
// deserializer that feeds a show-ahead FIFO with sticky overrun/framing flags.
module uart_transceiver #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned RX_DEPTH     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_we,
  output logic       tx_busy,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_re,
  input  logic       err_clr,
  output logic       rx_overrun,
  output logic       rx_frame_err,
  input  logic       uart_rxd,
  output logic       uart_txd
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned AW = $clog2(RX_DEPTH);
  localparam int unsigned PW = AW + 1;

  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]    tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    tx_shift_q, tx_shift_d;
  logic          txd_q, txd_d;

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          rxd_prev_q, rxd_prev_d;
  logic [1:0]    rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic          rx_push, rx_frame_set;

  logic [7:0]    mem_q [RX_DEPTH];
  logic [7:0]    mem_d [RX_DEPTH];
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic          ovr_q, ovr_d;
  logic          fe_q, fe_d;
  logic          fifo_empty, fifo_full, do_pop, do_push, ovr_set;

  // TX: txd_d carries the level of the bit being entered so the line is a flop.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    txd_d      = txd_q;
    case (tx_state_q)
      S_IDLE: begin
        if (tx_we) begin
          tx_shift_d = tx_data;
          tx_cnt_d   = '0;
          tx_state_d = S_START;
          txd_d      = 1'b0;
        end
      end
      S_START: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_state_d = S_DATA;
          txd_d      = tx_shift_q[0];
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = S_STOP;
            txd_d      = 1'b1;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            txd_d      = tx_shift_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      default: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_state_d = S_IDLE;
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
    endcase
  end

  // RX: only a synchronized 1->0 edge arms the receiver, so a stuck-low line stays idle.
  always_comb begin
    sync1_d      = uart_rxd;
    sync2_d      = sync1_q;
    rxd_prev_d   = sync2_q;
    rx_state_d   = rx_state_q;
    rx_cnt_d     = rx_cnt_q;
    rx_bit_d     = rx_bit_q;
    rx_shift_d   = rx_shift_q;
    rx_push      = 1'b0;
    rx_frame_set = 1'b0;
    case (rx_state_q)
      S_IDLE: begin
        if (rxd_prev_q && !sync2_q) begin
          rx_cnt_d   = '0;
          rx_state_d = S_START;
        end
      end
      S_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = sync2_q ? S_IDLE : S_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {sync2_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      default: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d     = '0;
          rx_state_d   = S_IDLE;
          rx_push      = sync2_q;
          rx_frame_set = !sync2_q;
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
    endcase
  end

  // A pop in the same cycle frees the slot, so push-while-full is only an overrun without one.
  always_comb begin
    fifo_empty = (wr_q == rd_q);
    fifo_full  = (wr_q[PW-1] != rd_q[PW-1]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    do_pop     = rx_re && !fifo_empty;
    do_push    = rx_push && (!fifo_full || do_pop);
    ovr_set    = rx_push && fifo_full && !do_pop;
    mem_d      = mem_q;
    if (do_push) mem_d[wr_q[AW-1:0]] = rx_shift_q;
    wr_d  = wr_q + PW'(do_push);
    rd_d  = rd_q + PW'(do_pop);
    ovr_d = ovr_set      ? 1'b1 : (err_clr ? 1'b0 : ovr_q);
    fe_d  = rx_frame_set ? 1'b1 : (err_clr ? 1'b0 : fe_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      txd_q      <= 1'b1;
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      rxd_prev_q <= 1'b1;
      rx_state_q <= S_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      mem_q      <= '{default: '0};
      wr_q       <= '0;
      rd_q       <= '0;
      ovr_q      <= 1'b0;
      fe_q       <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      txd_q      <= txd_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      rxd_prev_q <= rxd_prev_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      mem_q      <= mem_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      ovr_q      <= ovr_d;
      fe_q       <= fe_d;
    end
  end

  assign tx_busy      = (tx_state_q != S_IDLE);
  assign uart_txd     = txd_q;
  assign rx_valid     = !fifo_empty;
  assign rx_data      = fifo_empty ? 8'h00 : mem_q[rd_q[AW-1:0]];
  assign rx_overrun   = ovr_q;
  assign rx_frame_err = fe_q;

endmodule

// File: tb/tb_uart_transceiver.sv
// Bench for uart_transceiver at 16 clocks/bit, 4-deep RX FIFO; TX frames are
// decoded by a line monitor and RX bytes are scoreboarded against pops.
module tb_uart_transceiver;

  logic       clk;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_we;
  logic       tx_busy;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_re;
  logic       err_clr;
  logic       rx_overrun;
  logic       rx_frame_err;
  logic       uart_rxd;
  logic       uart_txd;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] tx_exp [$];
  logic [7:0] rx_exp [$];
  logic       tx_mon_en = 1'b1;

  uart_transceiver #(.CLKS_PER_BIT(16), .RX_DEPTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .tx_data     (tx_data),
    .tx_we       (tx_we),
    .tx_busy     (tx_busy),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_re       (rx_re),
    .err_clr     (err_clr),
    .rx_overrun  (rx_overrun),
    .rx_frame_err(rx_frame_err),
    .uart_rxd    (uart_rxd),
    .uart_txd    (uart_txd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic rx_frame(input logic [7:0] b, input logic stop_bit, input bit tchk);
    logic [9:0] fr;
    fr = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      for (int c = 0; c < 16; c++) begin
        @(negedge clk);
        if (tchk && i == 9 && c == 0) check_val("rx_valid_before_stop", 32'(rx_valid), 32'd0);
        uart_rxd = fr[i];
      end
    end
    @(negedge clk);
    uart_rxd = 1'b1;
    if (tchk) check_val("rx_valid_after_stop", 32'(rx_valid), 32'd1);
  endtask

  task automatic rx_pop(input string tag);
    logic [7:0] e;
    @(negedge clk);
    check_val({tag, "_valid"}, 32'(rx_valid), 32'd1);
    check_val({tag, "_exp_avail"}, 32'(rx_exp.size() != 0), 32'd1);
    if (rx_exp.size() != 0) begin
      e = rx_exp.pop_front();
      check_val({tag, "_data"}, 32'(rx_data), 32'(e));
    end
    rx_re = 1'b1;
    @(negedge clk);
    rx_re = 1'b0;
  endtask

  task automatic pulse_err_clr();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  // Line monitor: samples mid-bit, compares decoded bytes with the TX queue.
  initial begin
    forever begin
      @(negedge clk);
      if (tx_mon_en && rst && uart_txd == 1'b0) begin
        logic [7:0] got;
        repeat (7) @(negedge clk);
        check_val("tx_start_mid", 32'(uart_txd), 32'd0);
        for (int k = 0; k < 8; k++) begin
          repeat (16) @(negedge clk);
          got[k] = uart_txd;
        end
        repeat (16) @(negedge clk);
        check_val("tx_stop_mid", 32'(uart_txd), 32'd1);
        check_val("tx_frame_expected", 32'(tx_exp.size() != 0), 32'd1);
        if (tx_exp.size() != 0) check_val("tx_byte", 32'(got), 32'(tx_exp.pop_front()));
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [9:0] fr;
    rst = 1'b1; tx_data = '0; tx_we = 1'b0; rx_re = 1'b0; err_clr = 1'b0; uart_rxd = 1'b1;
    #1 rst = 1'b0;
    #1;
    check_val("rst_txd", 32'(uart_txd), 32'd1);
    check_val("rst_busy", 32'(tx_busy), 32'd0);
    check_val("rst_valid", 32'(rx_valid), 32'd0);
    check_val("rst_rx_data", 32'(rx_data), 32'h00);
    check_val("rst_ovr", 32'(rx_overrun), 32'd0);
    check_val("rst_fe", 32'(rx_frame_err), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    // TX 0xA5 with an ignored strobe mid-frame
    fr = {1'b1, 8'hA5, 1'b0};
    tx_data = 8'hA5; tx_we = 1'b1; tx_exp.push_back(8'hA5);
    for (int i = 0; i < 160; i++) begin
      @(negedge clk);
      check_val("tx_a5_line", 32'(uart_txd), 32'(fr[i / 16]));
      check_val("tx_a5_busy", 32'(tx_busy), 32'd1);
      tx_we = 1'b0;
      if (i == 50) begin tx_data = 8'hFF; tx_we = 1'b1; end
    end
    @(negedge clk);
    check_val("tx_a5_done_busy", 32'(tx_busy), 32'd0);
    check_val("tx_a5_done_line", 32'(uart_txd), 32'd1);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      check_val("tx_no_extra_line", 32'(uart_txd), 32'd1);
      check_val("tx_no_extra_busy", 32'(tx_busy), 32'd0);
    end

    // RX single byte and pop
    rx_exp.push_back(8'h3C);
    rx_frame(8'h3C, 1'b1, 1'b1);
    rx_pop("rx_3c");
    check_val("rx_3c_empty_valid", 32'(rx_valid), 32'd0);
    check_val("rx_3c_empty_data", 32'(rx_data), 32'h00);
    check_val("rx_3c_no_fe", 32'(rx_frame_err), 32'd0);

    // Overrun: fifth byte dropped
    for (int b = 1; b <= 5; b++) begin
      if (b <= 4) rx_exp.push_back(8'(b));
      rx_frame(8'(b), 1'b1, 1'b0);
      if (b == 4) check_val("ovr_not_yet", 32'(rx_overrun), 32'd0);
    end
    check_val("ovr_set", 32'(rx_overrun), 32'd1);
    for (int b = 1; b <= 4; b++) rx_pop("ovr_pop");
    check_val("ovr_drained_valid", 32'(rx_valid), 32'd0);
    check_val("ovr_drained_data", 32'(rx_data), 32'h00);
    pulse_err_clr();
    check_val("ovr_cleared", 32'(rx_overrun), 32'd0);

    // Framing error, then a long low line
    rx_frame(8'h55, 1'b0, 1'b0);
    uart_rxd = 1'b0;
    repeat (100) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (200) @(negedge clk);
    check_val("fe_set", 32'(rx_frame_err), 32'd1);
    check_val("fe_no_byte", 32'(rx_valid), 32'd0);
    check_val("fe_no_ovr", 32'(rx_overrun), 32'd0);
    pulse_err_clr();
    check_val("fe_cleared", 32'(rx_frame_err), 32'd0);

    // Glitch rejection
    @(negedge clk);
    uart_rxd = 1'b0;
    repeat (4) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (100) @(negedge clk);
    check_val("glitch_no_byte", 32'(rx_valid), 32'd0);
    check_val("glitch_no_fe", 32'(rx_frame_err), 32'd0);
    check_val("glitch_no_ovr", 32'(rx_overrun), 32'd0);
    rx_exp.push_back(8'hC3);
    rx_frame(8'hC3, 1'b1, 1'b1);
    rx_pop("glitch_follow");

    // Reset mid-frame in both directions
    tx_mon_en = 1'b0;
    fr = {1'b1, 8'h99, 1'b0};
    for (int c = 0; c <= 100; c++) begin
      @(negedge clk);
      uart_rxd = fr[c / 16];
      if (c == 30) begin tx_data = 8'h81; tx_we = 1'b1; end
      if (c == 31) tx_we = 1'b0;
    end
    check_val("pre_rst_busy", 32'(tx_busy), 32'd1);
    #2 rst = 1'b0;
    #1;
    check_val("midrst_txd", 32'(uart_txd), 32'd1);
    check_val("midrst_busy", 32'(tx_busy), 32'd0);
    check_val("midrst_valid", 32'(rx_valid), 32'd0);
    uart_rxd = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    check_val("post_rst_busy", 32'(tx_busy), 32'd0);
    check_val("post_rst_valid", 32'(rx_valid), 32'd0);
    check_val("post_rst_fe", 32'(rx_frame_err), 32'd0);
    tx_mon_en = 1'b1;

    // Full duplex after reset
    rx_exp.push_back(8'h7E);
    fork
      begin
        @(negedge clk);
        tx_data = 8'h5A; tx_we = 1'b1; tx_exp.push_back(8'h5A);
        @(negedge clk);
        tx_we = 1'b0;
      end
      rx_frame(8'h7E, 1'b1, 1'b1);
    join
    rx_pop("rx_7e");
    repeat (30) @(negedge clk);

    check_val("tx_q_drained", 32'(tx_exp.size()), 32'd0);
    check_val("rx_q_drained", 32'(rx_exp.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
